// File: rtl/multicycle_core_pkg.sv
// multicycle_core_pkg: opcodes, FSM states and instruction field positions.
// Define MULTICYCLE_MUL_EN to make opcode 12 (MUL) a legal instruction.
package multicycle_core_pkg;

    localparam int OP_MSB = 15;
    localparam int OP_LSB = 10;
    localparam int RA_MSB = 9;
    localparam int RA_LSB = 5;
    localparam int RB_MSB = 4;
    localparam int RB_LSB = 0;

    typedef enum logic [5:0] {
        OP_NOP  = 6'd0,
        OP_ADD  = 6'd1,
        OP_SUB  = 6'd2,
        OP_AND  = 6'd3,
        OP_OR   = 6'd4,
        OP_XOR  = 6'd5,
        OP_SLT  = 6'd6,
        OP_LI   = 6'd7,
        OP_LD   = 6'd8,
        OP_ST   = 6'd9,
        OP_BEQ  = 6'd10,
        OP_JAL  = 6'd11,
        OP_MUL  = 6'd12,
        OP_HALT = 6'd63
    } op_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH_IMM,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
            OP_LI, OP_LD, OP_ST, OP_BEQ, OP_JAL, OP_HALT: ok = 1'b1;
`ifdef MULTICYCLE_MUL_EN
            OP_MUL: ok = 1'b1;
`endif
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_core_regfile.sv
// core_regfile: two async read ports, one sync write port, r0 hardwired to zero.
module core_regfile #(
    parameter int DATA_W    = 16,
    parameter int REG_COUNT = 32,
    localparam int IDX_W    = $clog2(REG_COUNT)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IDX_W-1:0]  ra_addr_i,
    output logic [DATA_W-1:0] ra_data_o,
    input  logic [IDX_W-1:0]  rb_addr_i,
    output logic [DATA_W-1:0] rb_data_o,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] regs_q [REG_COUNT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o = (ra_addr_i == '0) ? '0 : regs_q[ra_addr_i];
    assign rb_data_o = (rb_addr_i == '0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/multicycle_core.sv
// multicycle_core: 16-bit-instruction multicycle CPU over a req/ack memory bus.
// Define MULTICYCLE_MUL_EN to add opcode 12 (MUL, low DATA_W bits of ra*rb).
module multicycle_core
    import multicycle_core_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int REG_COUNT = 32
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              halted,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int IDX_W = $clog2(REG_COUNT);

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] res_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              halted_q;
    logic              illegal_q;

    op_e               op;
    logic [IDX_W-1:0]  ra_idx;
    logic [IDX_W-1:0]  rb_idx;
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] alu_res;
    logic [ADDR_W-1:0] imm_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic              rf_we;

    assign op       = op_e'(ir_q[OP_MSB:OP_LSB]);
    assign ra_idx   = ir_q[RA_LSB +: IDX_W];
    assign rb_idx   = ir_q[RB_LSB +: IDX_W];
    assign imm_addr = ADDR_W'(imm_q);
    assign pc_inc   = pc_q + ADDR_W'(1);
    assign rf_we    = (state_q == S_WB);

    core_regfile #(
        .DATA_W    (DATA_W),
        .REG_COUNT (REG_COUNT)
    ) u_regfile (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .ra_addr_i (ra_idx),
        .ra_data_o (rf_a),
        .rb_addr_i (rb_idx),
        .rb_data_o (rf_b),
        .we_i      (rf_we),
        .waddr_i   (ra_idx),
        .wdata_i   (res_q)
    );

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = a_q - b_q;
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_XOR:  alu_res = a_q ^ b_q;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, (a_q < b_q)};
`ifdef MULTICYCLE_MUL_EN
            OP_MUL:  alu_res = a_q * b_q;
`endif
            default: alu_res = '0;
        endcase
    end

    // Bus outputs are registered: each transition into a bus state
    // presets them so the request is on the wire from the state's first cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            imm_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            illegal_q <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    if (!mem_req_q) begin
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= pc_q;
                    end else if (mem_ack) begin
                        ir_q      <= mem_rdata[15:0];
                        pc_q      <= pc_inc;
                        mem_req_q <= 1'b0;
                        state_q   <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q <= rf_a;
                    b_q <= rf_b;
                    case (op)
                        OP_LI, OP_BEQ, OP_JAL: begin
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= pc_q;
                            state_q    <= S_FETCH_IMM;
                        end
                        OP_HALT: begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                        default: begin
                            illegal_q <= !op_legal(ir_q[OP_MSB:OP_LSB]);
                            state_q   <= S_EXEC;
                        end
                    endcase
                end
                S_FETCH_IMM: begin
                    if (mem_req_q && mem_ack) begin
                        imm_q     <= mem_rdata;
                        pc_q      <= pc_inc;
                        mem_req_q <= 1'b0;
                        state_q   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT: begin
                            res_q   <= alu_res;
                            state_q <= S_WB;
                        end
`ifdef MULTICYCLE_MUL_EN
                        OP_MUL: begin
                            res_q   <= alu_res;
                            state_q <= S_WB;
                        end
`endif
                        OP_LI: begin
                            res_q   <= imm_q;
                            state_q <= S_WB;
                        end
                        OP_JAL: begin
                            res_q   <= DATA_W'(pc_q);
                            pc_q    <= imm_addr;
                            state_q <= S_WB;
                        end
                        OP_LD, OP_ST: begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= (op == OP_ST);
                            mem_addr_q  <= ADDR_W'(b_q);
                            mem_wdata_q <= a_q;
                            state_q     <= S_MEM;
                        end
                        OP_BEQ: begin
                            mem_req_q <= 1'b1;
                            mem_we_q  <= 1'b0;
                            if (a_q == b_q) begin
                                pc_q       <= imm_addr;
                                mem_addr_q <= imm_addr;
                            end else begin
                                mem_addr_q <= pc_q;
                            end
                            state_q <= S_FETCH;
                        end
                        default: begin
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= pc_q;
                            state_q    <= S_FETCH;
                        end
                    endcase
                end
                S_MEM: begin
                    if (mem_req_q && mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (op == OP_ST) begin
                            // FETCH re-raises mem_req, keeping a gap after the store.
                            state_q <= S_FETCH;
                        end else begin
                            res_q   <= mem_rdata;
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    mem_req_q  <= 1'b1;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= pc_q;
                    state_q    <= S_FETCH;
                end
                S_HALT: begin
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                    halted_q  <= 1'b1;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;
    assign pc_dbg    = pc_q;

endmodule

// File: tb/tb_multicycle_core.sv
// tb_multicycle_core: directed programs, bus transfers checked by a scoreboard.
module tb_multicycle_core;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        halted;
    logic        illegal;
    logic [15:0] pc_dbg;

    always #5 CLK = ~CLK;

    multicycle_core dut (
        .CLK       (CLK),
        .RST       (RST),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .halted    (halted),
        .illegal   (illegal),
        .pc_dbg    (pc_dbg)
    );

`ifdef MULTICYCLE_MUL_EN
    localparam logic [15:0] OP12_R1 = 16'h002A;
    localparam int          OP12_ILL = 0;
`else
    localparam logic [15:0] OP12_R1 = 16'h0007;
    localparam int          OP12_ILL = 1;
`endif

    logic [15:0]  prog [256];
    logic [15:0]  dmem [256];
    logic [255:0] wvalid;
    int           waits = 0;
    int           wcnt;
    int           ill_cycles = 0;

    assign mem_ack   = mem_req && (wcnt == waits);
    assign mem_rdata = wvalid[mem_addr[7:0]] ? dmem[mem_addr[7:0]]
                                             : prog[mem_addr[7:0]];

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wcnt   <= 0;
            wvalid <= '0;
        end else begin
            if (mem_req && !mem_ack) wcnt <= wcnt + 1;
            else wcnt <= 0;
            if (mem_req && mem_ack && mem_we) begin
                dmem[mem_addr[7:0]]   <= mem_wdata;
                wvalid[mem_addr[7:0]] <= 1'b1;
            end
        end
    end

    always @(negedge CLK) if (RST && illegal) ill_cycles <= ill_cycles + 1;

    typedef struct packed {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } xfer_t;

    xfer_t expq[$];
    xfer_t mon_e;
    int    checks = 0;
    int    passes = 0;

    always @(negedge CLK) begin
        if (RST && mem_req && mem_ack) begin
            checks++;
            if (expq.size() == 0) begin
                $display("FAIL xfer: unexpected we=%b addr=%h wdata=%h",
                         mem_we, mem_addr, mem_wdata);
            end else begin
                mon_e = expq.pop_front();
                if (mem_we === mon_e.we && mem_addr === mon_e.addr &&
                    (!mon_e.we || mem_wdata === mon_e.wdata))
                    passes++;
                else
                    $display("FAIL xfer: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata,
                             mon_e.we, mon_e.addr, mon_e.wdata);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, got, exp);
    endtask

    task automatic rd(input logic [15:0] a);
        expq.push_back({1'b0, a, 16'h0000});
    endtask

    task automatic rds(input int lo, input int hi);
        for (int a = lo; a <= hi; a++) rd(16'(a));
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        expq.push_back({1'b1, a, d});
    endtask

    task automatic ld(input int a, input logic [15:0] w);
        prog[a] = w;
    endtask

    task automatic start_prog(input int w);
        @(negedge CLK);
        RST   = 1'b0;
        waits = w;
        expq.delete();
        for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
    endtask

    task automatic wait_halt(input string name, input logic [15:0] pc_exp);
        for (int i = 0; i < 3000 && !halted; i++) @(negedge CLK);
        @(negedge CLK);
        chk({name, " halted"}, 32'(halted), 1);
        chk({name, " req idle"}, 32'(mem_req), 0);
        chk({name, " pc"}, 32'(pc_dbg), 32'(pc_exp));
        chk({name, " drained"}, expq.size(), 0);
    endtask

    int  n;
    int  n4;
    int  n5;
    int  c4;
    int  ill0;
    bit  found;

    initial begin
        // Program A: LI/LI/SUB timing, ST then LD through r2=0x40, HALT, reset.
        start_prog(0);
        ld(0, 16'h1C20); ld(1, 16'h0005); ld(2, 16'h1C40); ld(3, 16'h0003);
        ld(4, 16'h0822); ld(5, 16'h1C40); ld(6, 16'h0040); ld(7, 16'h2422);
        ld(8, 16'h2062); ld(9, 16'h1C80); ld(10, 16'h0041); ld(11, 16'h2464);
        ld(12, 16'hFC00);
        rds(0, 7); wr(16'h0040, 16'h0002); rd(8); rd(16'h0040);
        rds(9, 11); wr(16'h0041, 16'h0002); rd(12);
        #1;
        chk("reset req", 32'(mem_req), 0);
        chk("reset we", 32'(mem_we), 0);
        chk("reset halted", 32'(halted), 0);
        chk("reset illegal", 32'(illegal), 0);
        chk("reset pc", 32'(pc_dbg), 0);
        @(negedge CLK);
        RST = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (mem_req && mem_addr == 16'h0005) found = 1'b1;
        end
        chk("li_li_sub cycles", n, 15);
        wait_halt("progA", 16'd13);

        @(posedge CLK);
        #2;
        RST = 1'b0;
        #1;
        chk("async rst halted", 32'(halted), 0);
        chk("async rst req", 32'(mem_req), 0);
        chk("async rst pc", 32'(pc_dbg), 0);
        expq.delete();
        rd(16'h0000);
        @(negedge CLK);
        RST = 1'b1;
        n = 0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge CLK);
            n++;
            if (mem_req && mem_ack && mem_addr == 16'h0000) found = 1'b1;
        end
        chk("refetch edge", n, 1);
        @(negedge CLK);
        chk("refetch drained", expq.size(), 0);

        // Program B: 3 wait states, ALU patterns, r0 write discard, wrap.
        start_prog(3);
        ld(0, 16'h1C20); ld(1, 16'h1234); ld(2, 16'h1C40); ld(3, 16'h0F0F);
        ld(4, 16'h0422); ld(5, 16'h1C60); ld(6, 16'h0080); ld(7, 16'h2423);
        ld(8, 16'h0C22); ld(9, 16'h2423); ld(10, 16'h1422); ld(11, 16'h2423);
        ld(12, 16'h1822); ld(13, 16'h2423); ld(14, 16'h1841); ld(15, 16'h2443);
        ld(16, 16'h0841); ld(17, 16'h2443); ld(18, 16'h0401); ld(19, 16'h2403);
        ld(20, 16'h1022); ld(21, 16'h0000); ld(22, 16'h2423); ld(23, 16'hFC00);
        rds(0, 7); wr(16'h0080, 16'h2143);
        rds(8, 9); wr(16'h0080, 16'h0103);
        rds(10, 11); wr(16'h0080, 16'h0E0C);
        rds(12, 13); wr(16'h0080, 16'h0001);
        rds(14, 15); wr(16'h0080, 16'h0000);
        rds(16, 17); wr(16'h0080, 16'hFFFF);
        rds(18, 19); wr(16'h0080, 16'h0000);
        rds(20, 22); wr(16'h0080, 16'hFFFF); rd(23);
        @(negedge CLK);
        RST = 1'b1;
        n = 0; n4 = -1; n5 = -1; c4 = 0;
        for (int i = 0; i < 1000 && n5 < 0; i++) begin
            @(negedge CLK);
            n++;
            if (mem_req && mem_addr == 16'h0004 && !mem_we) begin
                c4++;
                if (n4 < 0) n4 = n;
            end
            if (mem_req && mem_addr == 16'h0005 && n5 < 0) n5 = n;
        end
        chk("add wait cycles", n5 - n4, 7);
        chk("add addr stable", c4, 4);
        wait_halt("progB", 16'd24);

        // Program C: BEQ taken/not taken, opcode 12, JAL, PC wrap into HALT.
        start_prog(0);
        ld(0, 16'h1C20); ld(1, 16'h0007); ld(2, 16'h1C40); ld(3, 16'h0006);
        ld(4, 16'h2884); ld(5, 16'h0020);
        ld(32, 16'h1CA0); ld(33, 16'h0009); ld(34, 16'h28A4); ld(35, 16'h0030);
        ld(36, 16'h3022); ld(37, 16'h1C60); ld(38, 16'h0080); ld(39, 16'h2423);
        ld(40, 16'h2C80); ld(41, 16'h0050);
        ld(80, 16'h2483); ld(81, 16'h2C00); ld(82, 16'hFFFF);
        ld(255, 16'hFC00);
        rds(0, 5); rds(32, 39); wr(16'h0080, OP12_R1);
        rds(40, 41); rd(16'h0050); wr(16'h0080, 16'h002A);
        rds(81, 82); rd(16'hFFFF);
        ill0 = ill_cycles;
        @(negedge CLK);
        RST = 1'b1;
        wait_halt("progC", 16'h0000);
        chk("op12 illegal cycles", ill_cycles - ill0, OP12_ILL);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
